// File: rtl/fetch_drv_pkg.sv
// Shared types for the fetch stream driver: queue slot layout and FSM state encoding.
package fetch_drv_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_slot_t;

  typedef logic [1:0] fetch_drv_state_t;

  localparam fetch_drv_state_t StIdle  = 2'd0;
  localparam fetch_drv_state_t StRun   = 2'd1;
  localparam fetch_drv_state_t StDrain = 2'd2;
  localparam fetch_drv_state_t StDone  = 2'd3;

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO accepting up to LANES pushes and LANES pops per cycle, with a
// show-ahead window of LANES entries starting at the head.
module fetch_queue
  import fetch_drv_pkg::*;
#(
  parameter int unsigned LANES  = 2,
  parameter int unsigned QDEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [$clog2(LANES+1)-1:0]   push_n,
  input  fetch_slot_t                  push_data [LANES],
  input  logic [$clog2(LANES+1)-1:0]   pop_n,
  input  logic                         clear,
  output fetch_slot_t                  head_data [LANES],
  output logic [$clog2(QDEPTH+1)-1:0]  count
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned NW = $clog2(LANES + 1);
  localparam int unsigned CW = $clog2(QDEPTH + 1);

  fetch_slot_t   mem_q [QDEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + PW'(push_n);
      rd_ptr_q <= rd_ptr_q + PW'(pop_n);
      count_q  <= count_q + CW'(push_n) - CW'(pop_n);
    end
  end

  // Storage has no reset; validity is tracked purely by count_q.
  always_ff @(posedge clk) begin
    if (!rst && !clear) begin
      for (int i = 0; i < int'(LANES); i++) begin
        if (NW'(i) < push_n) begin
          mem_q[wr_ptr_q + PW'(i)] <= push_data[i];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < int'(LANES); i++) begin
      head_data[i] = mem_q[rd_ptr_q + PW'(i)];
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_stream_driver.sv
// Preloaded program image streamed LANES instructions per cycle into decode,
// with pause back-pressure and flush-with-redirect.
module fetch_stream_driver
  import fetch_drv_pkg::*;
#(
  parameter int unsigned LANES   = 2,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned QDEPTH  = 8,
  parameter logic [31:0] PC_BASE = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_we,
  input  logic [$clog2(DEPTH)-1:0]   load_addr,
  input  logic [31:0]                load_data,
  input  logic [$clog2(DEPTH):0]     prog_len,
  input  logic                       start,
  input  logic                       pause,
  input  logic                       flush,
  input  logic [31:0]                flush_pc,
  output logic [LANES-1:0]           out_valid,
  output logic [LANES*32-1:0]        out_inst,
  output logic [LANES*32-1:0]        out_pc,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned NW = $clog2(LANES + 1);
  localparam int unsigned CW = $clog2(QDEPTH + 1);

  logic [31:0]      mem [DEPTH];
  fetch_drv_state_t state_q, state_d;
  logic [AW:0]      prog_len_q;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      end_pc;
  logic [31:0]      redirect_pc;
  logic [AW-1:0]    fetch_word;
  logic [NW-1:0]    push_n, pop_n;
  logic             q_clear;
  fetch_slot_t      push_data [LANES];
  fetch_slot_t      head_data [LANES];
  logic [CW-1:0]    count;

  assign end_pc      = PC_BASE + (32'(prog_len_q) << 2);
  assign redirect_pc = flush_pc & ~32'h3;
  assign fetch_word  = AW'((fetch_pc_q - PC_BASE) >> 2);

  // Program image: written only while idle, never reset.
  always_ff @(posedge clk) begin
    if (state_q == StIdle && load_we) begin
      mem[load_addr] <= load_data;
    end
  end

  // Push a group only when a full LANES worth of space is free; the tail group may be short.
  always_comb begin
    push_n = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      push_data[i].pc   = fetch_pc_q + 32'(4 * i);
      push_data[i].inst = mem[fetch_word + AW'(i)];
    end
    if (state_q == StRun && !flush && int'(count) + int'(LANES) <= int'(QDEPTH)) begin
      for (int i = 0; i < int'(LANES); i++) begin
        if (push_data[i].pc < end_pc) begin
          push_n = NW'(i + 1);
        end
      end
    end
  end

  always_comb begin
    pop_n = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      if (out_valid[i] && !pause) begin
        pop_n = NW'(i + 1);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < int'(LANES); i++) begin
      out_valid[i]      = int'(count) > i;
      out_inst[32*i+:32] = out_valid[i] ? head_data[i].inst : 32'h0;
      out_pc[32*i+:32]   = out_valid[i] ? head_data[i].pc   : 32'h0;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    q_clear    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StRun;
          fetch_pc_d = PC_BASE;
        end
      end
      StRun: begin
        if (fetch_pc_q >= end_pc) begin
          state_d = StDrain;
        end else begin
          fetch_pc_d = fetch_pc_q + (32'(push_n) << 2);
        end
      end
      StDrain: begin
        if (count == '0) begin
          state_d = StDone;
        end
      end
      StDone: ;
      default: state_d = StIdle;
    endcase
    if (flush && state_q != StIdle) begin
      q_clear    = 1'b1;
      fetch_pc_d = redirect_pc;
      // Offset compare covers both PC_BASE <= pc and pc < end_pc in one unsigned test.
      state_d    = ((redirect_pc - PC_BASE) < (end_pc - PC_BASE)) ? StRun : StDrain;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      fetch_pc_q <= PC_BASE;
      prog_len_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      if (state_q == StIdle && start) begin
        prog_len_q <= prog_len;
      end
    end
  end

  fetch_queue #(
    .LANES  (LANES),
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push_n    (push_n),
    .push_data (push_data),
    .pop_n     (pop_n),
    .clear     (q_clear),
    .head_data (head_data),
    .count     (count)
  );

  assign busy = (state_q == StRun) || (state_q == StDrain);
  assign done = (state_q == StDone);

endmodule

// File: tb/tb_fetch_stream_driver.sv
// Directed bench: a 2-lane instance for the scenario checks and a 4-lane instance
// for a long paused stream with mid-run reset and replay.
module tb_fetch_stream_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // 2-lane instance
  logic        rst, load_we, start, pause, flush;
  logic [9:0]  load_addr;
  logic [31:0] load_data, flush_pc;
  logic [10:0] prog_len;
  logic [1:0]  out_valid;
  logic [63:0] out_inst, out_pc;
  logic        busy, done;

  fetch_stream_driver #(
    .LANES(2), .DEPTH(1024), .QDEPTH(8), .PC_BASE(32'h0)
  ) dut (
    .clk(clk), .rst(rst), .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .prog_len(prog_len), .start(start), .pause(pause), .flush(flush), .flush_pc(flush_pc),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc), .busy(busy), .done(done)
  );

  // 4-lane instance
  logic         rst4, load_we4, start4, pause4, flush4;
  logic [9:0]   load_addr4;
  logic [31:0]  load_data4, flush_pc4;
  logic [10:0]  prog_len4;
  logic [3:0]   out_valid4;
  logic [127:0] out_inst4, out_pc4;
  logic         busy4, done4;

  fetch_stream_driver #(
    .LANES(4), .DEPTH(1024), .QDEPTH(8), .PC_BASE(32'h0)
  ) dut4 (
    .clk(clk), .rst(rst4), .load_we(load_we4), .load_addr(load_addr4), .load_data(load_data4),
    .prog_len(prog_len4), .start(start4), .pause(pause4), .flush(flush4),
    .flush_pc(flush_pc4), .out_valid(out_valid4), .out_inst(out_inst4), .out_pc(out_pc4),
    .busy(busy4), .done(done4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic start_prog(input logic [10:0] len);
    prog_len = len;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; load_we = 0; start = 0; pause = 0; flush = 0;
    load_addr = '0; load_data = '0; flush_pc = '0; prog_len = '0;
    tick();
    tick();
    rst = 1'b0;
    n_checks++; if (out_valid !== 2'b00) begin n_fail++; $display("FAIL reset_valid: got %b expected 00", out_valid); end
    n_checks++; if (out_pc !== 64'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected 0", out_pc); end
    n_checks++; if (out_inst !== 64'h0) begin n_fail++; $display("FAIL reset_inst: got %h expected 0", out_inst); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    for (int i = 0; i < 8; i++) begin
      load_we = 1'b1; load_addr = 10'(i); load_data = 32'h100 + 32'(i);
      tick();
    end
    load_we = 1'b0;
  endtask

  task automatic test_stream6();
    do_reset();
    start_prog(11'd6);
    n_checks++; if (out_valid !== 2'b00) begin n_fail++; $display("FAIL s6_first: got %b expected 00", out_valid); end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (out_valid !== 2'b11 || out_pc !== {32'(8*k+4), 32'(8*k)} ||
          out_inst !== {32'h101 + 32'(2*k), 32'h100 + 32'(2*k)}) begin
        n_fail++;
        $display("FAIL s6_group%0d: got v=%b pc=%h inst=%h expected pc %h/%h", k, out_valid,
                 out_pc, out_inst, 8*k, 8*k+4);
      end
    end
    tick();
    n_checks++; if (out_valid !== 2'b00 || done !== 1'b0) begin n_fail++; $display("FAIL s6_drain: got v=%b done=%b expected 00/0", out_valid, done); end
    tick();
    n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL s6_done: got done=%b busy=%b expected 1/0", done, busy); end
  endtask

  task automatic test_partial5();
    do_reset();
    start_prog(11'd5);
    tick();
    tick();
    tick();
    n_checks++; if (out_valid !== 2'b01) begin n_fail++; $display("FAIL p5_valid: got %b expected 01", out_valid); end
    n_checks++; if (out_pc !== 64'h10) begin n_fail++; $display("FAIL p5_pc: got %h expected 10", out_pc); end
    n_checks++; if (out_inst !== 64'h104) begin n_fail++; $display("FAIL p5_inst: got %h expected 104", out_inst); end
  endtask

  task automatic test_pause();
    do_reset();
    start_prog(11'd6);
    tick();
    n_checks++; if (out_pc !== {32'h4, 32'h0}) begin n_fail++; $display("FAIL pause_pre: got %h expected 4/0", out_pc); end
    pause = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (out_valid !== 2'b11 || out_pc !== {32'h4, 32'h0} || out_inst !== {32'h101, 32'h100}) begin
        n_fail++;
        $display("FAIL pause_hold%0d: got v=%b pc=%h inst=%h expected 11/4,0/101,100", k,
                 out_valid, out_pc, out_inst);
      end
    end
    pause = 1'b0;
    tick();
    n_checks++; if (out_pc !== {32'hC, 32'h8} || out_valid !== 2'b11) begin n_fail++; $display("FAIL pause_rel0: got v=%b pc=%h expected C/8", out_valid, out_pc); end
    tick();
    n_checks++; if (out_pc !== {32'h14, 32'h10} || out_inst !== {32'h105, 32'h104}) begin n_fail++; $display("FAIL pause_rel1: got pc=%h inst=%h expected 14/10", out_pc, out_inst); end
    tick();
    n_checks++; if (out_valid !== 2'b00) begin n_fail++; $display("FAIL pause_empty: got %b expected 00", out_valid); end
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 30) begin
      tick();
      n++;
    end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL %s: got done=%b expected 1 within 30 cycles", name, done); end
  endtask

  task automatic test_flush();
    do_reset();
    start_prog(11'd6);
    tick();
    tick();
    n_checks++; if (out_pc[31:0] !== 32'h8) begin n_fail++; $display("FAIL flush_head: got %h expected 8", out_pc[31:0]); end
    flush = 1'b1; flush_pc = 32'h1;
    tick();
    flush = 1'b0;
    n_checks++; if (out_valid !== 2'b00 || busy !== 1'b1) begin n_fail++; $display("FAIL flush_gap: got v=%b busy=%b expected 00/1", out_valid, busy); end
    tick();
    n_checks++; if (out_valid !== 2'b11 || out_pc !== {32'h4, 32'h0}) begin n_fail++; $display("FAIL flush_redirect: got v=%b pc=%h expected 11/4,0", out_valid, out_pc); end
    wait_done("flush_done0");
    flush = 1'b1; flush_pc = 32'h4;
    tick();
    flush = 1'b0;
    n_checks++; if (out_valid !== 2'b00 || busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL flush_done_gap: got v=%b busy=%b done=%b expected 00/1/0", out_valid, busy, done); end
    tick();
    n_checks++; if (out_pc !== {32'h8, 32'h4} || out_inst !== {32'h102, 32'h101}) begin n_fail++; $display("FAIL flush_re0: got pc=%h inst=%h expected 8,4/102,101", out_pc, out_inst); end
    tick();
    n_checks++; if (out_pc !== {32'h10, 32'hC}) begin n_fail++; $display("FAIL flush_re1: got pc=%h expected 10,C", out_pc); end
    tick();
    n_checks++; if (out_valid !== 2'b01 || out_pc !== 64'h14 || out_inst !== 64'h105) begin n_fail++; $display("FAIL flush_re2: got v=%b pc=%h inst=%h expected 01/14/105", out_valid, out_pc, out_inst); end
  endtask

  task automatic test_flush_end();
    wait_done("fend_pre");
    flush = 1'b1; flush_pc = 32'h18;
    tick();
    flush = 1'b0;
    n_checks++; if (out_valid !== 2'b00 || busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL fend_drain: got v=%b busy=%b done=%b expected 00/1/0", out_valid, busy, done); end
    tick();
    n_checks++; if (out_valid !== 2'b00 || done !== 1'b1) begin n_fail++; $display("FAIL fend_done: got v=%b done=%b expected 00/1", out_valid, done); end
  endtask

  task automatic test_load_ignored();
    load_we = 1'b1; load_addr = 10'd0; load_data = 32'hDEAD_BEEF;
    tick();
    load_we = 1'b0;
    do_reset();
    start_prog(11'd6);
    tick();
    n_checks++; if (out_inst[31:0] !== 32'h100) begin n_fail++; $display("FAIL load_ignored: got %h expected 100", out_inst[31:0]); end
  endtask

  // Checks each consumed slot against an incrementing PC model; returns next expected PC.
  task automatic run4(input int cycles, input logic [31:0] pc_in, output logic [31:0] pc_out);
    logic [31:0] exp_pc;
    logic        p;
    exp_pc = pc_in;
    for (int c = 0; c < cycles && !done4; c++) begin
      tick();
      n_checks++;
      if (!(out_valid4 inside {4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111}) ||
          dut4.u_queue.count > 4'd8) begin
        n_fail++;
        $display("FAIL l4_invariant: got v=%b count=%0d expected contiguous, <=8", out_valid4,
                 dut4.u_queue.count);
      end
      p = 1'($urandom_range(0, 1));
      pause4 = p;
      if (!p) begin
        for (int i = 0; i < 4; i++) begin
          if (out_valid4[i]) begin
            n_checks++;
            if (out_pc4[32*i+:32] !== exp_pc || out_inst4[32*i+:32] !== (32'hC000_0000 | (exp_pc >> 2))) begin
              n_fail++;
              $display("FAIL l4_slot: got pc=%h inst=%h expected pc=%h", out_pc4[32*i+:32],
                       out_inst4[32*i+:32], exp_pc);
            end
            exp_pc = exp_pc + 32'h4;
          end
        end
      end
    end
    pause4 = 1'b0;
    pc_out = exp_pc;
  endtask

  task automatic test_lanes4();
    logic [31:0] pc_end;
    rst4 = 1'b1; load_we4 = 0; start4 = 0; pause4 = 0; flush4 = 0;
    load_addr4 = '0; load_data4 = '0; flush_pc4 = '0; prog_len4 = 11'd1000;
    tick();
    rst4 = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      load_we4 = 1'b1; load_addr4 = 10'(i); load_data4 = 32'hC000_0000 | 32'(i);
      tick();
    end
    load_we4 = 1'b0;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    run4(300, 32'h0, pc_end);
    rst4 = 1'b1;
    tick();
    rst4 = 1'b0;
    n_checks++; if (busy4 !== 1'b0 || out_valid4 !== 4'b0 || done4 !== 1'b0 || out_pc4 !== 128'h0) begin n_fail++; $display("FAIL l4_rst: got busy=%b v=%b done=%b expected idle", busy4, out_valid4, done4); end
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    run4(6000, 32'h0, pc_end);
    n_checks++; if (done4 !== 1'b1) begin n_fail++; $display("FAIL l4_done: got %b expected 1", done4); end
    n_checks++; if (pc_end !== 32'hFA0) begin n_fail++; $display("FAIL l4_count: got next pc %h expected FA0", pc_end); end
  endtask

  initial begin
    test_reset();
    test_stream6();
    test_partial5();
    test_pause();
    test_flush();
    test_flush_end();
    test_load_ignored();
    test_lanes4();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
